// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row synchronisation, per-sweep
// classification, multi-sweep debounce and one-shot key reporting.
// Optional macro KEYPAD_SHIFT_EN adds a 16-bit shift register of entered
// key codes on the digits port.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [3:0]  col,
    input  logic [3:0]  row,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held
`ifdef KEYPAD_SHIFT_EN
   ,output logic [15:0] digits
`endif
);

    localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {
        CLS_NONE  = 2'd0,
        CLS_ONE   = 2'd1,
        CLS_MULTI = 2'd2
    } sweep_cls_e;

    typedef struct packed {
        sweep_cls_e cls;
        logic [3:0] code;
    } sweep_res_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESSED = 1'b1
    } state_e;

    logic [3:0]        row_s1, row_s2;
    logic [SLOT_W-1:0] slot_cnt;
    logic [1:0]        col_idx;
    logic              slot_last;
    logic              sweep_end;

    logic [3:0]        row_low;
    logic [2:0]        n_low;
    logic [1:0]        first_row;
    logic [3:0]        sample_code;
    logic [1:0]        acc_cnt, acc_cnt_nx;
    logic [3:0]        acc_code, acc_code_nx;
    logic [2:0]        acc_sum;
    sweep_res_t        sweep_res;

    sweep_res_t        cand;
    logic [CNT_W-1:0]  stable_cnt;
    logic              stable;
    logic              sweep_done;

    state_e            state_q, state_d;
    logic [3:0]        key_code_d;
    logic              key_held_d;
    logic              key_valid_d;

    // Map a (row, column) position to its printed hex legend.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    assign slot_last = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
    assign sweep_end = slot_last && (col_idx == 2'd3);
    assign stable    = (stable_cnt == CNT_W'(DEBOUNCE_SCANS));

    // Two-flop synchroniser on the asynchronous row inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1 <= 4'h0;
            row_s2 <= 4'h0;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
        end
    end

    // Slot timer and column rotation; the column moves on each slot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            col_idx  <= 2'd0;
            col      <= 4'b1110;
        end else if (slot_last) begin
            slot_cnt <= '0;
            col_idx  <= col_idx + 2'd1;
            col      <= {col[2:0], col[3]};
        end else begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
        end
    end

    // Fold the current slot's sample into the running sweep accumulator.
    always_comb begin
        row_low   = ~row_s2;
        n_low     = 3'(row_low[0]) + 3'(row_low[1]) + 3'(row_low[2]) + 3'(row_low[3]);
        first_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (row_low[r]) first_row = 2'(r);
        end
        sample_code = key_map(first_row, col_idx);
        acc_sum     = 3'(acc_cnt) + n_low;
        acc_cnt_nx  = (acc_sum >= 3'd2) ? 2'd2 : acc_sum[1:0];
        acc_code_nx = (acc_cnt == 2'd0 && n_low == 3'd1) ? sample_code : acc_code;
        sweep_res.cls  = (acc_cnt_nx == 2'd0) ? CLS_NONE :
                         (acc_cnt_nx == 2'd1) ? CLS_ONE  : CLS_MULTI;
        sweep_res.code = (acc_cnt_nx == 2'd1) ? acc_code_nx : 4'h0;
    end

    // Sweep accumulator: low-bit count saturating at two, plus first code seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt  <= 2'd0;
            acc_code <= 4'h0;
        end else if (sweep_end) begin
            acc_cnt  <= 2'd0;
            acc_code <= 4'h0;
        end else if (slot_last) begin
            acc_cnt  <= acc_cnt_nx;
            acc_code <= acc_code_nx;
        end
    end

    // Stability tracker: count consecutive identical sweep results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand       <= '{cls: CLS_NONE, code: 4'h0};
            stable_cnt <= '0;
            sweep_done <= 1'b0;
        end else begin
            sweep_done <= sweep_end;
            if (sweep_end) begin
                if (sweep_res == cand) begin
                    if (!stable) stable_cnt <= CNT_W'(stable_cnt + 1'b1);
                end else begin
                    cand       <= sweep_res;
                    stable_cnt <= CNT_W'(1);
                end
            end
        end
    end

    // Debounce FSM state and registered key outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            key_code  <= 4'h0;
            key_held  <= 1'b0;
            key_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_code  <= key_code_d;
            key_held  <= key_held_d;
            key_valid <= key_valid_d;
        end
    end

    // Debounce FSM next state: one report per press, release needs stable NONE.
    always_comb begin
        state_d     = state_q;
        key_code_d  = key_code;
        key_held_d  = key_held;
        key_valid_d = 1'b0;
        if (sweep_done && stable) begin
            case (state_q)
                ST_IDLE: begin
                    if (cand.cls == CLS_ONE) begin
                        state_d     = ST_PRESSED;
                        key_code_d  = cand.code;
                        key_held_d  = 1'b1;
                        key_valid_d = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (cand.cls == CLS_NONE) begin
                        state_d    = ST_IDLE;
                        key_held_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

`ifdef KEYPAD_SHIFT_EN
    // Shift each accepted key into the rightmost display nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits <= 16'h0000;
        end else if (key_valid_d) begin
            digits <= {digits[11:0], key_code_d};
        end
    end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=2).
// Keypad is modelled as a 16-bit pressed mask; rows respond combinationally
// to the column drive. Reference model works at whole-sweep granularity.
// Define KEYPAD_SHIFT_EN to also cover the digits shift register.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
`ifdef KEYPAD_SHIFT_EN
    logic [15:0] digits;
`endif

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col       (col),
        .row       (row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
`ifdef KEYPAD_SHIFT_EN
       ,.digits    (digits)
`endif
    );

    always #5 clk = ~clk;

    // Pressed keys, bit index = row*4 + col.
    logic [15:0] mask = 16'h0;
    logic [3:0]  kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'h0, 4'hF, 4'hE, 4'hD};

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (mask[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int valid_seen = 0;
    int last_valid_cyc = -1;
    int last_fall_cyc = -1;

    // Sweep-level reference model.
    int          m_cand_cls, m_cnt;
    logic [3:0]  m_cand_code;
    bit          m_pressed, m_pending;
    logic [3:0]  m_key;
    logic [15:0] m_digits;

    task automatic model_reset();
        m_cand_cls = 0; m_cand_code = 4'h0; m_cnt = 0;
        m_pressed = 0; m_pending = 0; m_key = 4'h0; m_digits = 16'h0;
        cyc = 0;
    endtask

    task automatic model_sweep_end(input logic [15:0] m);
        int n, cls;
        logic [3:0] code;
        n = $countones(m);
        cls = (n == 0) ? 0 : (n == 1) ? 1 : 2;
        code = 4'h0;
        if (cls == 1)
            for (int i = 0; i < 16; i++) if (m[i]) code = kmap[i];
        if (cls == m_cand_cls && code == m_cand_code) begin
            if (m_cnt < DEB) m_cnt++;
        end else begin
            m_cand_cls = cls; m_cand_code = code; m_cnt = 1;
        end
        if (m_cnt == DEB) begin
            if (!m_pressed && cls == 1) begin
                m_pressed = 1; m_key = code; m_pending = 1;
                m_digits = {m_digits[11:0], code};
            end else if (m_pressed && cls == 0) begin
                m_pressed = 0;
            end
        end
    endtask

    // One full sweep with the given keys held; every cycle is checked.
    task automatic run_sweep(input logic [15:0] m);
        bit vp;
        bit prev_held;
        logic [3:0] ecol;
        mask = m;
        vp = m_pending;
        m_pending = 0;
        for (int j = 1; j <= 16; j++) begin
            prev_held = key_held;
            @(posedge clk); #1;
            cyc++;
            ecol = ~(4'b0001 << ((j / 4) % 4));
            checks++;
            if (col !== ecol) begin
                errors++;
                $display("FAIL col cyc=%0d got=%b exp=%b", cyc, col, ecol);
            end
            checks++;
            if (key_valid !== (vp && j == 1)) begin
                errors++;
                $display("FAIL key_valid cyc=%0d got=%b exp=%b", cyc, key_valid, vp && j == 1);
            end
            checks++;
            if (key_held !== m_pressed) begin
                errors++;
                $display("FAIL key_held cyc=%0d got=%b exp=%b", cyc, key_held, m_pressed);
            end
            checks++;
            if (key_code !== m_key) begin
                errors++;
                $display("FAIL key_code cyc=%0d got=%h exp=%h", cyc, key_code, m_key);
            end
`ifdef KEYPAD_SHIFT_EN
            checks++;
            if (digits !== m_digits) begin
                errors++;
                $display("FAIL digits cyc=%0d got=%h exp=%h", cyc, digits, m_digits);
            end
`endif
            if (key_valid === 1'b1) begin
                valid_seen++;
                last_valid_cyc = cyc;
            end
            if (prev_held === 1'b1 && key_held === 1'b0) last_fall_cyc = cyc;
        end
        model_sweep_end(m);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (col !== 4'b1110 || key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'h0) begin
            errors++;
            $display("FAIL %s got col=%b v=%b h=%b code=%h exp col=1110 v=0 h=0 code=0",
                     tag, col, key_valid, key_held, key_code);
        end
`ifdef KEYPAD_SHIFT_EN
        checks++;
        if (digits !== 16'h0000) begin
            errors++;
            $display("FAIL %s_digits got=%h exp=0000", tag, digits);
        end
`endif
    endtask

    // Assert reset off-edge, check immediately and while held, release on negedge.
    task automatic do_reset(input string tag);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs({tag, "_async"});
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs({tag, "_held"});
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        mask = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_initial");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_sweep(16'h0);
        run_sweep(16'h0);
    endtask

    task automatic test_single_press();
        int v0;
        do_reset("single_rst");
        v0 = valid_seen;
        repeat (3) run_sweep(16'h0020);
        checks++;
        if (valid_seen - v0 != 1 || last_valid_cyc != 33) begin
            errors++;
            $display("FAIL single_latency got pulses=%0d at cyc=%0d exp 1 at 33",
                     valid_seen - v0, last_valid_cyc);
        end
    endtask

    task automatic test_long_hold();
        int v0;
        int start;
        v0 = valid_seen;
        repeat (20) run_sweep(16'h0020);
        start = cyc;
        repeat (3) run_sweep(16'h0);
        checks++;
        if (valid_seen != v0) begin
            errors++;
            $display("FAIL hold_repeat got extra pulses=%0d exp 0", valid_seen - v0);
        end
        checks++;
        if (last_fall_cyc != start + 33) begin
            errors++;
            $display("FAIL hold_release got fall cyc=%0d exp %0d", last_fall_cyc, start + 33);
        end
        checks++;
        if (key_code !== 4'h5) begin
            errors++;
            $display("FAIL hold_code got=%h exp=5", key_code);
        end
    endtask

    task automatic test_bounce();
        int v0;
        v0 = valid_seen;
        for (int i = 0; i < 5; i++) run_sweep((i % 2 == 0) ? 16'h8000 : 16'h0000);
        checks++;
        if (valid_seen != v0) begin
            errors++;
            $display("FAIL bounce_quiet got pulses=%0d exp 0", valid_seen - v0);
        end
        repeat (3) run_sweep(16'h8000);
        checks++;
        if (valid_seen != v0 + 1 || key_code !== 4'hD) begin
            errors++;
            $display("FAIL bounce_accept got pulses=%0d code=%h exp 1 code=D",
                     valid_seen - v0, key_code);
        end
        repeat (3) run_sweep(16'h0);
    endtask

    task automatic test_multi();
        int v0;
        v0 = valid_seen;
        repeat (10) run_sweep(16'h0009);
        checks++;
        if (valid_seen != v0 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL multi_block got pulses=%0d held=%b exp 0 held=0",
                     valid_seen - v0, key_held);
        end
        repeat (3) run_sweep(16'h0001);
        checks++;
        if (valid_seen != v0 + 1 || key_code !== 4'h1) begin
            errors++;
            $display("FAIL multi_release got pulses=%0d code=%h exp 1 code=1",
                     valid_seen - v0, key_code);
        end
        repeat (3) run_sweep(16'h0);
    endtask

    task automatic test_random();
        logic [15:0] m;
        int sel;
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3)      m = 16'h0;
            else if (sel < 8) m = 16'h1 << $urandom_range(0, 15);
            else              m = 16'($urandom) | (16'h1 << $urandom_range(0, 15)) | 16'h0100;
            repeat ($urandom_range(1, 4)) run_sweep(m);
        end
        repeat (3) run_sweep(16'h0);
    endtask

    task automatic test_reset_mid();
        repeat (3) run_sweep(16'h0400);
        mask = 16'h0400;
        repeat (6) @(posedge clk);
        do_reset("midsweep_rst");
        repeat (3) run_sweep(16'h0400);
        checks++;
        if (last_valid_cyc != 33 || key_code !== 4'h9) begin
            errors++;
            $display("FAIL midsweep_restart got cyc=%0d code=%h exp 33 code=9",
                     last_valid_cyc, key_code);
        end
        repeat (3) run_sweep(16'h0);
    endtask

`ifdef KEYPAD_SHIFT_EN
    task automatic test_shift();
        logic [15:0] keys [4] = '{16'h0001, 16'h0002, 16'h0004, 16'h0010};
        do_reset("shift_rst");
        for (int k = 0; k < 4; k++) begin
            repeat (3) run_sweep(keys[k]);
            repeat (3) run_sweep(16'h0);
        end
        checks++;
        if (digits !== 16'h1234) begin
            errors++;
            $display("FAIL shift_digits got=%h exp=1234", digits);
        end
        repeat (7) @(posedge clk);
        do_reset("shift_midrst");
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_single_press();
        test_long_hold();
        test_bounce();
        test_multi();
        test_random();
        test_reset_mid();
`ifdef KEYPAD_SHIFT_EN
        test_shift();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
